// File: rtl/pipeline_hazard_controller_pkg.sv
// Purpose: shared encodings for the decode-stage interlock and flush sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   hazState_t  - sequencer state, visible on the controller's state port
//   sbEntry_t   - one scoreboard slot: {valid, dest}
//   REG_ZERO    - hard-wired zero register, never a dependency
//   REG_RA      - link register written by jal
package pipeline_hazard_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } hazState_t;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
  } sbEntry_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Purpose: shift-register record of in-flight destination registers plus RAW match on rs/rt.
// Latency: a load is visible to the match logic the cycle after it is presented; match is combinational.
// Backpressure: none; the register shifts every cycle, and the caller gates what enters entry 0.
//
// Ports:
//   clk, reset         - rising-edge clock, async active-high reset (clears every entry)
//   loadValid/loadDest - candidate for entry 0 (youngest, ID/EX)
//   squash             - wrong-path kill: entries 0 and 1 load invalid on this edge
//   rsAddr/rtAddr      - decode source registers to compare
//   rsMatch/rtMatch    - some valid in-range entry holds that destination
module hazard_scoreboard
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int SB_DEPTH  = 3,
  parameter bit WB_BYPASS = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       loadValid,
  input  logic [4:0] loadDest,
  input  logic       squash,
  input  logic [4:0] rsAddr,
  input  logic [4:0] rtAddr,
  output logic       rsMatch,
  output logic       rtMatch
);

  // With a write-through register file, the MEM/WB producer's data is already
  // visible to decode, so the oldest slot drops out of the compare.
  localparam int MATCH_DEPTH = WB_BYPASS ? SB_DEPTH - 1 : SB_DEPTH;

  sbEntry_t entries [SB_DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      entries[0].valid <= loadValid & ~squash;
      entries[0].dest  <= loadDest;
      for (int i = 1; i < SB_DEPTH; i++) begin
        // Slot 1 receives what sat in ID/EX: younger than the redirecting
        // instruction in MEM, so it is on the wrong path and is dropped.
        entries[i].valid <= entries[i-1].valid & ~(squash && (i == 1));
        entries[i].dest  <= entries[i-1].dest;
      end
    end
  end

  always_comb begin
    rsMatch = 1'b0;
    rtMatch = 1'b0;
    for (int i = 0; i < MATCH_DEPTH; i++) begin
      if (entries[i].valid && (entries[i].dest == rsAddr)) rsMatch = 1'b1;
      if (entries[i].valid && (entries[i].dest == rtAddr)) rtMatch = 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Purpose: RAW interlock and MEM-stage redirect flush sequencer for a 5-stage core without forwarding.
// Latency: enables/flushes are combinational in the same cycle; state and counters update on the next edge.
// Backpressure: a RAW hazard holds PC and IF/ID and injects a bubble into ID/EX until the producer leaves range.
//
// Ports:
//   clk, reset                   - rising-edge clock, async active-high reset
//   id_valid, id_rs, id_rt,
//   id_uses_rs, id_uses_rt       - decode-stage instruction and which sources it reads
//   id_reg_write, id_write_reg   - decode-stage destination (already resolved to rt/rd/31)
//   redirect_mem                 - taken branch / jump / jr resolving in MEM
//   pc_enable, if_id_enable      - front-end load enables
//   if_id_flush, id_ex_flush,
//   ex_mem_flush                 - clear the named pipeline register on the next edge
//   state                        - 00 RUN, 01 STALL, 10 FLUSH
//   stall_cycles, flush_events   - saturating performance counters
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int SB_DEPTH  = 3,
  parameter bit WB_BYPASS = 1'b0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [4:0]           id_rs,
  input  logic [4:0]           id_rt,
  input  logic                 id_uses_rs,
  input  logic                 id_uses_rt,
  input  logic                 id_reg_write,
  input  logic [4:0]           id_write_reg,
  input  logic                 redirect_mem,
  output logic                 pc_enable,
  output logic                 if_id_enable,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 ex_mem_flush,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_events
);

  hazState_t            stateQ;
  logic [CNT_WIDTH-1:0] stallCnt;
  logic [CNT_WIDTH-1:0] flushCnt;

  logic inFlush;
  logic rsMatch;
  logic rtMatch;
  logic rsHazard;
  logic rtHazard;
  logic hazard;
  logic sbLoad;

  // The cycle after a redirect, ID holds a cleared instruction, so whatever
  // is on the decode inputs is not real: no interlock and no scoreboard entry.
  assign inFlush = (stateQ == ST_FLUSH);

  hazard_scoreboard #(
    .SB_DEPTH  (SB_DEPTH),
    .WB_BYPASS (WB_BYPASS)
  ) uScoreboard (
    .clk       (clk),
    .reset     (reset),
    .loadValid (sbLoad),
    .loadDest  (id_write_reg),
    .squash    (redirect_mem),
    .rsAddr    (id_rs),
    .rtAddr    (id_rt),
    .rsMatch   (rsMatch),
    .rtMatch   (rtMatch)
  );

  // $0 is hard-wired, so it is never a real dependency in either direction.
  assign rsHazard = id_uses_rs && (id_rs != REG_ZERO) && rsMatch;
  assign rtHazard = id_uses_rt && (id_rt != REG_ZERO) && rtMatch;
  assign hazard   = id_valid && !inFlush && (rsHazard || rtHazard);

  // A stalled instruction stays in ID and re-presents itself, so it is only
  // recorded on the cycle it actually moves into EX.
  assign sbLoad = id_valid && id_reg_write && (id_write_reg != REG_ZERO)
                  && !hazard && !inFlush;

  // Redirect wins over a hazard: the stalled instruction is wrong-path anyway.
  always_comb begin
    pc_enable    = 1'b1;
    if_id_enable = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (!reset) begin
      if (redirect_mem) begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (hazard) begin
        pc_enable    = 1'b0;
        if_id_enable = 1'b0;
        id_ex_flush  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ   <= ST_RUN;
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (redirect_mem) begin
        stateQ <= ST_FLUSH;
      end else if (hazard) begin
        stateQ <= ST_STALL;
      end else begin
        stateQ <= ST_RUN;
      end

      if (hazard && !redirect_mem && (stallCnt != '1)) begin
        stallCnt <= stallCnt + CNT_WIDTH'(1);
      end
      if (redirect_mem && (flushCnt != '1)) begin
        flushCnt <= flushCnt + CNT_WIDTH'(1);
      end
    end
  end

  assign state        = stateQ;
  assign stall_cycles = stallCnt;
  assign flush_events = flushCnt;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Purpose: randomized and directed checking of three controller variants against an issue-history model.
// Latency: outputs sampled 1 time unit after inputs change at the falling edge.
// Backpressure: n/a.
module tb_pipeline_hazard_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       idValid = 1'b0;
  logic [4:0] idRs = '0;
  logic [4:0] idRt = '0;
  logic       idUsesRs = 1'b0;
  logic       idUsesRt = 1'b0;
  logic       idRegWrite = 1'b0;
  logic [4:0] idWriteReg = '0;
  logic       redirectMem = 1'b0;

  logic        pcEn    [3];
  logic        ifIdEn  [3];
  logic        ifIdFl  [3];
  logic        idExFl  [3];
  logic        exMemFl [3];
  logic [1:0]  st      [3];
  logic [15:0] scO     [3];
  logic [15:0] fcO     [3];
  logic [3:0]  scSmall;
  logic [3:0]  fcSmall;

  assign scO[2] = 16'(scSmall);
  assign fcO[2] = 16'(fcSmall);

  always #5 clk = ~clk;

  // dut0: default; dut1: write-through register file; dut2: 4-bit counters
  pipeline_hazard_controller #(.SB_DEPTH(3), .WB_BYPASS(1'b0), .CNT_WIDTH(16)) dut0 (
    .clk(clk), .reset(reset), .id_valid(idValid), .id_rs(idRs), .id_rt(idRt),
    .id_uses_rs(idUsesRs), .id_uses_rt(idUsesRt), .id_reg_write(idRegWrite),
    .id_write_reg(idWriteReg), .redirect_mem(redirectMem),
    .pc_enable(pcEn[0]), .if_id_enable(ifIdEn[0]), .if_id_flush(ifIdFl[0]),
    .id_ex_flush(idExFl[0]), .ex_mem_flush(exMemFl[0]), .state(st[0]),
    .stall_cycles(scO[0]), .flush_events(fcO[0]));

  pipeline_hazard_controller #(.SB_DEPTH(3), .WB_BYPASS(1'b1), .CNT_WIDTH(16)) dut1 (
    .clk(clk), .reset(reset), .id_valid(idValid), .id_rs(idRs), .id_rt(idRt),
    .id_uses_rs(idUsesRs), .id_uses_rt(idUsesRt), .id_reg_write(idRegWrite),
    .id_write_reg(idWriteReg), .redirect_mem(redirectMem),
    .pc_enable(pcEn[1]), .if_id_enable(ifIdEn[1]), .if_id_flush(ifIdFl[1]),
    .id_ex_flush(idExFl[1]), .ex_mem_flush(exMemFl[1]), .state(st[1]),
    .stall_cycles(scO[1]), .flush_events(fcO[1]));

  pipeline_hazard_controller #(.SB_DEPTH(3), .WB_BYPASS(1'b0), .CNT_WIDTH(4)) dut2 (
    .clk(clk), .reset(reset), .id_valid(idValid), .id_rs(idRs), .id_rt(idRt),
    .id_uses_rs(idUsesRs), .id_uses_rt(idUsesRt), .id_reg_write(idRegWrite),
    .id_write_reg(idWriteReg), .redirect_mem(redirectMem),
    .pc_enable(pcEn[2]), .if_id_enable(ifIdEn[2]), .if_id_flush(ifIdFl[2]),
    .id_ex_flush(idExFl[2]), .ex_mem_flush(exMemFl[2]), .state(st[2]),
    .stall_cycles(scSmall), .flush_events(fcSmall));

  int errors = 0;
  int checks = 0;
  int cyc    = 32;

  // Reference model: which destination was issued into EX in each cycle.
  // An instruction issued in cycle c blocks readers in cycles c+1 .. c+window.
  // A redirect in cycle c kills whatever issues in c and what issued in c-1.
  bit          issued   [3][16];
  logic [4:0]  issuedTo [3][16];
  bit          prevRedir[3];
  bit          prevHaz  [3];
  int unsigned stallRef [3];
  int unsigned flushRef [3];
  int          window   [3] = '{3, 2, 3};
  int unsigned cntMax   [3] = '{32'd65535, 32'd65535, 32'd15};

  task automatic check(input string tag, input int inst, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h exp=%0h", tag, inst, cyc, got, exp);
    end
  endtask

  function automatic bit inFlight(input int k, input logic [4:0] r);
    for (int a = 1; a <= window[k]; a++) begin
      if (issued[k][(cyc - a) & 15] && issuedTo[k][(cyc - a) & 15] == r) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic step(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                      input bit ur, input bit ut, input bit rw, input logic [4:0] wr,
                      input bit redir, input bit rst);
    bit haz;
    int expState;
    @(negedge clk);
    reset = rst; idValid = v; idRs = rs; idRt = rt; idUsesRs = ur; idUsesRt = ut;
    idRegWrite = rw; idWriteReg = wr; redirectMem = redir;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        for (int i = 0; i < 16; i++) issued[k][i] = 1'b0;
        prevRedir[k] = 1'b0;
        prevHaz[k]   = 1'b0;
        stallRef[k]  = 0;
        flushRef[k]  = 0;
        check("rst_pc_enable", k, 32'(pcEn[k]), 32'd1);
        check("rst_if_id_enable", k, 32'(ifIdEn[k]), 32'd1);
        check("rst_flushes", k, 32'({ifIdFl[k], idExFl[k], exMemFl[k]}), 32'd0);
        check("rst_state", k, 32'(st[k]), 32'd0);
        check("rst_counters", k, {scO[k], fcO[k]}, 32'd0);
      end else begin
        haz = v && !prevRedir[k] &&
              ((ur && rs != 5'd0 && inFlight(k, rs)) || (ut && rt != 5'd0 && inFlight(k, rt)));
        expState = prevRedir[k] ? 2 : (prevHaz[k] ? 1 : 0);
        check("pc_enable", k, 32'(pcEn[k]), 32'(redir || !haz));
        check("if_id_enable", k, 32'(ifIdEn[k]), 32'(redir || !haz));
        check("flushes", k, 32'({ifIdFl[k], idExFl[k], exMemFl[k]}),
              32'({redir, redir || haz, redir}));
        check("state", k, 32'(st[k]), 32'(expState));
        check("stall_cycles", k, 32'(scO[k]), stallRef[k]);
        check("flush_events", k, 32'(fcO[k]), flushRef[k]);
        issued[k][cyc & 15]   = v && rw && wr != 5'd0 && !haz && !prevRedir[k] && !redir;
        issuedTo[k][cyc & 15] = wr;
        if (redir) issued[k][(cyc - 1) & 15] = 1'b0;
        if (haz && !redir && stallRef[k] < cntMax[k]) stallRef[k]++;
        if (redir && flushRef[k] < cntMax[k]) flushRef[k]++;
        prevRedir[k] = redir;
        prevHaz[k]   = haz;
      end
    end
    cyc++;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // reset, including a redirect that must be ignored while reset is high
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 2, 1, 1, 1, 3, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // independent stream: add $1,$3,$4 ; add $2,$3,$4
    step(1, 3, 4, 1, 1, 1, 1, 0, 0);
    step(1, 3, 4, 1, 1, 1, 2, 0, 0);
    nop(4);

    // add $5 then sub $6,$5,$3 held in decode
    step(1, 3, 4, 1, 1, 1, 5, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 5, 3, 1, 1, 1, 6, 0, 0);
    nop(4);

    // rt-side dependency
    step(1, 3, 4, 1, 1, 1, 9, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 3, 9, 1, 1, 1, 10, 0, 0);
    nop(4);

    // writes to $0 never create a dependency
    step(1, 3, 4, 1, 1, 1, 0, 0, 0);
    step(1, 0, 0, 1, 1, 1, 8, 0, 0);
    step(1, 0, 0, 1, 1, 1, 11, 0, 0);
    nop(4);

    // redirect while a hazard is present, then the same reader after the flush
    step(1, 3, 4, 1, 1, 1, 7, 0, 0);
    step(1, 7, 3, 1, 1, 1, 12, 1, 0);
    step(1, 7, 3, 1, 1, 1, 12, 0, 0);
    step(1, 7, 3, 1, 1, 1, 12, 0, 0);
    // back-to-back redirects keep FLUSH
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    nop(4);

    // addi $5,$5,1 repeated: long-running stalls saturate the 4-bit counters
    for (int i = 0; i < 30; i++) step(1, 5, 0, 1, 0, 1, 5, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 3, 4, 1, 1, 1, 5, 0, 0);
    step(1, 5, 0, 1, 0, 1, 5, 0, 0);
    // reset in the middle of a stall, then resume with the same reader
    step(1, 5, 0, 1, 0, 1, 5, 0, 1);
    step(1, 5, 0, 1, 0, 1, 5, 0, 0);
    step(1, 5, 0, 1, 0, 1, 5, 0, 0);
    nop(3);

    // random traffic on a small register window to provoke frequent hazards
    for (int i = 0; i < 700; i++) begin
      step($urandom_range(7, 0) != 0, 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
           1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
           5'($urandom_range(7, 0)), $urandom_range(9, 0) == 0, $urandom_range(199, 0) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
